// File: rtl/shift_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_rx_pkg
// Purpose  : Shared types and constants for the shift_rx serial receiver.
//            rx_state_t   - receiver FSM state encoding
//            c_DEFAULT_WIDTH - default word length in bits
// Revision : 1.0 - initial release
// ============================================================================
package shift_rx_pkg;

   localparam int c_DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      WAIT  = 2'd2
   } rx_state_t;

endpackage : shift_rx_pkg
`default_nettype wire

// File: rtl/shift_rx_sreg.sv
`default_nettype none
// ============================================================================
// Module   : shift_rx_sreg
// Purpose  : WIDTH-bit right-shift register (LSB-first reception) with a
//            saturating bit counter and a last-bit flag.
// Ports    : Clk       in   rising-edge clock
//            Reset_n   in   asynchronous active-low reset
//            Clear     in   clears register and counter (frame start)
//            Shift_En  in   shift Shift_In in at the MSB end, count the bit
//            Shift_In  in   serial data bit
//            Sreg      out  current register contents
//            Word_Next out  register contents as they would be after a shift
//            Last      out  the next accepted bit completes the word
// Revision : 1.0 - initial release
// ============================================================================
module shift_rx_sreg
   import shift_rx_pkg::*;
#(
   parameter int WIDTH = c_DEFAULT_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Clear,
   input  logic             Shift_En,
   input  logic             Shift_In,
   output logic [WIDTH-1:0] Sreg,
   output logic [WIDTH-1:0] Word_Next,
   output logic             Last
);

   localparam int                 c_CNT_W    = $clog2(WIDTH);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0]   r_sreg;
   logic [c_CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0]   w_shifted;

   // First-received bit ends up in bit 0 after WIDTH shifts.
   assign w_shifted = {Shift_In, r_sreg[WIDTH-1:1]};

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_sreg <= '0;
         r_cnt  <= '0;
      end else if (Clear) begin
         r_sreg <= '0;
         r_cnt  <= '0;
      end else if (Shift_En) begin
         r_sreg <= w_shifted;
         // Saturate instead of wrapping; the next frame start resets it.
         if (r_cnt != c_CNT_LAST) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign Sreg      = r_sreg;
   assign Word_Next = w_shifted;
   assign Last      = (r_cnt == c_CNT_LAST);

endmodule : shift_rx_sreg
`default_nettype wire

// File: rtl/shift_rx_8.sv
`default_nettype none
// ============================================================================
// Module   : shift_rx_8
// Purpose  : Serial-to-parallel receiver. Frames WIDTH-bit LSB-first words,
//            buffers one completed word on a valid/ready output and can
//            hold a second fully assembled word while the first is unread.
// Ports    : Clk        in   rising-edge clock
//            Reset_n    in   asynchronous active-low reset
//            Start      in   one-cycle pulse opening a new frame
//            Bit_En     in   Shift_In is valid this cycle
//            Shift_In   in   serial data, LSB first
//            Ready      in   consumer accepts Data_Out
//            Clear_Err  in   clears Err (a simultaneous set wins)
//            Data_Out   out  received word
//            Valid      out  Data_Out holds an unread word
//            Busy       out  receiver is not idle
//            Err        out  sticky protocol-error flag
// Revision : 1.0 - initial release
// ============================================================================
module shift_rx_8
   import shift_rx_pkg::*;
#(
   parameter int WIDTH = c_DEFAULT_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Bit_En,
   input  logic             Shift_In,
   input  logic             Ready,
   input  logic             Clear_Err,
   output logic [WIDTH-1:0] Data_Out,
   output logic             Valid,
   output logic             Busy,
   output logic             Err
);

   rx_state_t        r_state;
   rx_state_t        w_state_next;

   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_err;

   logic             w_sreg_clear;
   logic             w_sreg_shift;
   logic             w_load_new;
   logic             w_load_held;
   logic             w_err_set;
   logic             w_transfer;
   logic             w_hold_free;
   logic             w_last;
   logic [WIDTH-1:0] w_sreg;
   logic [WIDTH-1:0] w_word_next;

   shift_rx_sreg #(
      .WIDTH (WIDTH)
   ) u_sreg (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .Clear     (w_sreg_clear),
      .Shift_En  (w_sreg_shift),
      .Shift_In  (Shift_In),
      .Sreg      (w_sreg),
      .Word_Next (w_word_next),
      .Last      (w_last)
   );

   assign w_transfer  = r_valid && Ready;
   // The holding register can accept a word if empty or being read now.
   assign w_hold_free = !r_valid || Ready;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_sreg_clear = 1'b0;
      w_sreg_shift = 1'b0;
      w_load_new   = 1'b0;
      w_load_held  = 1'b0;
      w_err_set    = 1'b0;
      unique case (r_state)
         IDLE: begin
            // Stray Bit_En here (including alongside Start) is ignored.
            if (Start) begin
               w_state_next = SHIFT;
               w_sreg_clear = 1'b1;
            end
         end
         SHIFT: begin
            if (Start) begin
               // Restart: drop the partial word and flag it.
               w_sreg_clear = 1'b1;
               w_err_set    = 1'b1;
            end else if (Bit_En) begin
               w_sreg_shift = 1'b1;
               if (w_last) begin
                  if (w_hold_free) begin
                     w_load_new   = 1'b1;
                     w_state_next = IDLE;
                  end else begin
                     // Full word stays parked in the shift register.
                     w_state_next = WAIT;
                  end
               end
            end
         end
         WAIT: begin
            if (w_transfer) begin
               w_load_held  = 1'b1;
               w_state_next = IDLE;
            end
            if (Bit_En || Start) begin
               w_err_set = 1'b1;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         if (w_load_new) begin
            r_data <= w_word_next;
         end else if (w_load_held) begin
            r_data <= w_sreg;
         end
         // A load on the same edge as a transfer keeps Valid high.
         if (w_load_new || w_load_held) begin
            r_valid <= 1'b1;
         end else if (w_transfer) begin
            r_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_err <= 1'b0;
      end else if (w_err_set) begin
         r_err <= 1'b1;
      end else if (Clear_Err) begin
         r_err <= 1'b0;
      end
   end

   assign Data_Out = r_data;
   assign Valid    = r_valid;
   assign Busy     = (r_state != IDLE);
   assign Err      = r_err;

endmodule : shift_rx_8
`default_nettype wire

// File: doc/shift_rx_8.md
# shift_rx_8

Serial-to-parallel receiver that collects an LSB-first bit stream, one bit per strobe, from a right-shifting transmit register: bit 0 is sent first. It frames WIDTH-bit words, buffers one completed word, and presents it on a valid/ready output. A second word can be assembled while the buffered word waits to be read. It sits between a serial link and the datapath that consumes parallel bytes.

## Interface
- WIDTH, 8, word length in bits; must be ≥ 2.
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- Start  in  1  one-cycle pulse that opens a new frame.
- Bit_En  in  1  strobe; Shift_In is valid in this cycle.
- Shift_In  in  1  serial data, LSB first.
- Ready  in  1  consumer accepts Data_Out.
- Data_Out  out  WIDTH  received word.
- Valid  out  1  Data_Out holds an unread word.
- Busy  out  1  receiver is not in IDLE.
- Err  out  1  sticky protocol-error flag.
- Clear_Err  in  1  clears Err.

## Operation
- States: IDLE, SHIFT, WAIT.
- IDLE:
  - Start → SHIFT; bit count = 0; shift register cleared.
  - Bit_En is ignored, with no error.
  - Bit_En in the same cycle as Start is ignored.
- SHIFT, on each Bit_En:
  - shift register <= {Shift_In, sreg[WIDTH-1:1]};
  - count++.
- Completion: Bit_En while count == WIDTH-1.
  - Holding register free (Valid == 0, or Valid && Ready this cycle): assembled word, including the current bit, loads into Data_Out; Valid <= 1; → IDLE.
  - Holding register not free: → WAIT with the full word held in the shift register.
- WAIT:
  - When the holding register becomes free (Valid && Ready): shift register loads into Data_Out the same edge; Valid stays 1; → IDLE.
  - Bit_En: bit dropped; Err <= 1.
  - Start: ignored; Err <= 1.
- Start in SHIFT: partial word discarded; count = 0; remain in SHIFT; Err <= 1.
- Output handshake:
  - A transfer occurs on an edge where Valid && Ready.
  - Valid then drops, unless a new word loads on the same edge.
  - Data_Out is stable while Valid && !Ready.
- Err:
  - Set by the events listed above.
  - Cleared by Clear_Err.
  - If a set event and Clear_Err occur in the same cycle, set wins.
- Busy = (state != IDLE).
- Count width: $clog2(WIDTH). Count never wraps; it resets on frame start.

## Timing
- Reset (Reset_n low, asynchronous):
  - state IDLE, count 0, shift register 0.
  - Data_Out 0, Valid 0, Busy 0, Err 0.
- Reset mid-frame discards all in-flight and buffered data.
- Latency: Valid rises on the edge that samples the final Bit_En, so it is visible 1 cycle after the last bit.
- WAIT → release: the word appears on Data_Out the edge after the Ready handshake of the previous word, with Valid continuously high.
- Minimum bit spacing: one bit per cycle (Bit_En held high is legal). A frame of WIDTH bits plus Start takes ≥ WIDTH+1 cycles.
- Busy rises the edge after Start and falls on the edge the word reaches Data_Out.

## Structure
- Package shift_rx_pkg contains:
  - rx_state_t enum {IDLE, SHIFT, WAIT};
  - the default WIDTH constant.
- Sub-module shift_rx_sreg: WIDTH-bit right-shift register with clear and shift enable, plus the bit counter and a last-bit flag.
- The top level holds the FSM, the holding register, the Valid/Ready logic and Err.

## Test plan
- Start; bits 1,0,1,0,0,1,0,1 on consecutive cycles; Ready=1 → Valid high for 1 cycle, Data_Out=0xA5, Err=0, Busy falls with Valid rising.
- Back-pressure:
  - Stimulus: Ready=0; receive 0x3C, then frame 0x81; one extra Bit_En while in WAIT; then Ready=1.
  - After 0x81 completes: Busy=1 (WAIT).
  - After the extra Bit_En: Err=1.
  - After Ready=1: 0x3C transfers; next cycle Data_Out=0x81 with Valid still 1; Busy=0.
- Restart: Start, 3 bits, Start, 8 bits of 1 → Data_Out=0xFF, Err=1; Clear_Err → Err=0.
- Reset: Reset_n low for 1 cycle after 4 bits of a frame → all outputs 0 immediately. A following Bit_En ×8 without Start → Valid stays 0, Err stays 0.
- Simultaneous events:
  - Clear_Err in the same cycle as Start-in-SHIFT → Err=1.
  - Final Bit_En in the same cycle as a Valid&&Ready transfer → new word loads, Valid stays 1.
